// File: rtl/tray_height_tracker_pkg.sv
// Shared types for the tray height conditioning stage.
package tray_height_tracker_pkg;

  typedef enum logic [1:0] {
    StFill  = 2'b00,
    StTrack = 2'b01,
    StFault = 2'b10
  } state_e;

  // Consecutive out-of-range samples that force a refill.
  localparam int unsigned GlitchDropLimit = 3;

endpackage

// File: rtl/tray_avg_window.sv
// Moving-average window: ring buffer with running sum, fill count and flush.
module tray_avg_window
  import tray_height_tracker_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 32,
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic                flush,
  input  logic [SAMPLE_W-1:0] sample,
  output logic [SAMPLE_W-1:0] avg,
  output logic                full
);

  localparam int unsigned Depth = 1 << AVG_LOG2;
  localparam int unsigned SumW  = SAMPLE_W + AVG_LOG2;

  logic [SAMPLE_W-1:0] win_q [Depth];
  logic [AVG_LOG2-1:0] wr_ptr_q;
  logic [AVG_LOG2:0]   cnt_q;
  logic [SumW-1:0]     sum_q;

  assign full = (cnt_q == (AVG_LOG2 + 1)'(Depth));
  assign avg  = SAMPLE_W'(sum_q >> AVG_LOG2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) win_q[i] <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      sum_q    <= '0;
    end else if (flush) begin
      // Empty slots must read as zero so the running sum stays exact while refilling.
      for (int i = 0; i < Depth; i++) win_q[i] <= '0;
      if (push) win_q[0] <= sample;
      wr_ptr_q <= push ? AVG_LOG2'(1) : '0;
      cnt_q    <= push ? (AVG_LOG2 + 1)'(1) : '0;
      sum_q    <= push ? SumW'(sample) : '0;
    end else if (push) begin
      win_q[wr_ptr_q] <= sample;
      wr_ptr_q        <= wr_ptr_q + AVG_LOG2'(1);
      sum_q           <= sum_q + SumW'(sample) - SumW'(win_q[wr_ptr_q]);
      if (!full) cnt_q <= cnt_q + (AVG_LOG2 + 1)'(1);
    end
  end

endmodule

// File: rtl/tray_height_tracker.sv
// Tray height conditioning: moving average, cm quantiser with hysteresis, sample timeout.
// Optional glitch rejection when TRAY_GLITCH_REJECT_EN is defined.
module tray_height_tracker
  import tray_height_tracker_pkg::*;
#(
  parameter int unsigned SAMPLE_W  = 32,
  parameter int unsigned FRAC_W    = 4,
  parameter int unsigned STATION_W = 8,
  parameter int unsigned AVG_LOG2  = 2,
  parameter int unsigned HYST      = 2,
  parameter int unsigned TIMEOUT   = 1000,
  parameter int unsigned GLITCH_TH = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_vld,
  input  logic [SAMPLE_W-1:0]  tray_height,
  output logic [STATION_W-1:0] tray_station,
  output logic                 station_valid,
  output logic                 station_changed,
  output logic                 sensor_fault
);

  localparam int unsigned CmW = SAMPLE_W - FRAC_W;
  localparam int unsigned ToW = $clog2(TIMEOUT);
  localparam logic [CmW-1:0] StationMax = CmW'((1 << STATION_W) - 1);

  state_e               state_q;
  logic [ToW-1:0]       to_cnt_q;
  logic                 upd_q;
  logic                 push, flush, glitch_flush, to_hit, full;
  logic [SAMPLE_W-1:0]  avg;
  logic [CmW-1:0]       q_raw;
  logic [STATION_W-1:0] q_sat, q_diff;

  assign q_raw  = CmW'(avg >> FRAC_W);
  assign q_sat  = (q_raw > StationMax) ? '1 : q_raw[STATION_W-1:0];
  assign q_diff = (q_sat >= tray_station) ? q_sat - tray_station : tray_station - q_sat;
  // A sample arriving on the timeout cycle keeps the sensor alive.
  assign to_hit = !sample_vld && (to_cnt_q == ToW'(TIMEOUT - 1));

`ifdef TRAY_GLITCH_REJECT_EN
  logic [1:0]     drop_cnt_q;
  logic [CmW-1:0] cm, st_ext, cm_diff;
  logic           is_glitch;

  assign cm           = CmW'(tray_height >> FRAC_W);
  assign st_ext       = CmW'(tray_station);
  assign cm_diff      = (cm >= st_ext) ? cm - st_ext : st_ext - cm;
  assign is_glitch    = sample_vld && (state_q == StTrack) && (cm_diff > CmW'(GLITCH_TH));
  assign glitch_flush = is_glitch && (drop_cnt_q == 2'(GlitchDropLimit - 1));
  assign push         = sample_vld && (!is_glitch || glitch_flush);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else if (state_q != StTrack || glitch_flush) begin
      drop_cnt_q <= '0;
    end else if (sample_vld) begin
      drop_cnt_q <= is_glitch ? drop_cnt_q + 2'd1 : 2'd0;
    end
  end
`else
  // GLITCH_TH has no effect in this build.
  assign glitch_flush = (GLITCH_TH == 0) && 1'b0;
  assign push         = sample_vld;
`endif

  assign flush = ((state_q == StFault) && sample_vld) || glitch_flush;

  tray_avg_window #(
    .SAMPLE_W (SAMPLE_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_window (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .flush  (flush),
    .sample (tray_height),
    .avg    (avg),
    .full   (full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StFill;
      to_cnt_q        <= '0;
      upd_q           <= 1'b0;
      tray_station    <= '0;
      station_valid   <= 1'b0;
      station_changed <= 1'b0;
      sensor_fault    <= 1'b0;
    end else begin
      upd_q           <= push;
      station_changed <= 1'b0;
      to_cnt_q        <= (sample_vld || to_hit || state_q == StFault) ? '0 : to_cnt_q + ToW'(1);
      case (state_q)
        StFill: begin
          if (full) begin
            state_q         <= StTrack;
            tray_station    <= q_sat;
            station_changed <= 1'b1;
            station_valid   <= 1'b1;
          end else if (to_hit) begin
            state_q      <= StFault;
            sensor_fault <= 1'b1;
          end
        end
        StTrack: begin
          // The pending update belongs to an earlier sample, so it lands even on a refill.
          if (upd_q && q_diff >= STATION_W'(HYST)) begin
            tray_station    <= q_sat;
            station_changed <= 1'b1;
          end
          if (glitch_flush) begin
            state_q       <= StFill;
            station_valid <= 1'b0;
          end else if (to_hit) begin
            state_q       <= StFault;
            station_valid <= 1'b0;
            sensor_fault  <= 1'b1;
          end
        end
        StFault: begin
          if (sample_vld) begin
            state_q      <= StFill;
            sensor_fault <= 1'b0;
          end
        end
        default: state_q <= StFill;
      endcase
    end
  end

endmodule

// File: tb/tb_tray_height_tracker.sv
// Bench for tray_height_tracker: directed scenarios plus randomized samples vs a window model.
module tb_tray_height_tracker;

  localparam int unsigned TO = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        sample_vld = 1'b0;
  logic [31:0] tray_height = '0;
  logic [7:0]  tray_station;
  logic        station_valid, station_changed, sensor_fault;

  int n_vec = 0;
  int n_err = 0;
  int pulse_cnt = 0;

  // Reference model: last four accepted samples and the spec's station rules.
  int unsigned win[$];
  int m_st = 0;
  int m_valid = 0;
  int m_state = 0;  // 0 filling, 1 tracking, 2 faulted
  int m_pulses = 0;
  int m_drops = 0;

  tray_height_tracker #(
    .TIMEOUT (TO)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sample_vld      (sample_vld),
    .tray_height     (tray_height),
    .tray_station    (tray_station),
    .station_valid   (station_valid),
    .station_changed (station_changed),
    .sensor_fault    (sensor_fault)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && station_changed === 1'b1) pulse_cnt++;

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic int model_q();
    longint unsigned s = 0;
    foreach (win[i]) s += longint'(win[i]);
    s = s / 64;  // divide by window size and by 16 fractional steps per cm
    return (s > 255) ? 255 : int'(s);
  endfunction

  task automatic model_push(input int unsigned h);
    int q;
`ifdef TRAY_GLITCH_REJECT_EN
    if (m_state == 1) begin
      if (absd(int'(h >> 4), m_st) > 20) begin
        m_drops++;
        if (m_drops < 3) return;
        m_drops = 0;
        win.delete();
        win.push_back(h);
        m_state = 0;
        m_valid = 0;
        return;
      end
      m_drops = 0;
    end
`endif
    if (m_state == 2) begin
      win.delete();
      m_state = 0;
    end
    win.push_back(h);
    if (win.size() > 4) void'(win.pop_front());
    q = model_q();
    if (m_state == 0 && win.size() == 4) begin
      m_st = q;
      m_pulses++;
      m_state = 1;
      m_valid = 1;
    end else if (m_state == 1 && absd(q, m_st) >= 2) begin
      m_st = q;
      m_pulses++;
    end
  endtask

  task automatic model_reset();
    win.delete();
    m_st = 0;
    m_valid = 0;
    m_state = 0;
    m_drops = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] h, input int gap);
    sample_vld  = 1'b1;
    tray_height = h;
    tick(1);
    sample_vld  = 1'b0;
    tray_height = $urandom;
    model_push(h);
    if (gap > 0) tick(gap);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cm, gap;
    #2 rst_n = 1'b0;
    tick(2);
    check("rst_station", tray_station, 0);
    check("rst_valid", station_valid, 0);
    check("rst_changed", station_changed, 0);
    check("rst_fault", sensor_fault, 0);
    rst_n = 1'b1;
    tick(1);

    // First fill: four back-to-back 50 cm samples, station two cycles after the last.
    for (int i = 0; i < 4; i++) send(32'h320, 0);
    check("fill_valid_early", station_valid, 0);
    tick(1);
    check("fill_station", tray_station, 50);
    check("fill_valid", station_valid, 1);
    check("fill_pulse", station_changed, 1);
    tick(1);
    check("fill_pulse_single", station_changed, 0);

    // Hysteresis: 51 cm holds, 53 cm steps once the average reaches 52.
    for (int i = 0; i < 4; i++) begin
      send(51 * 16, 2);
      check("hyst51_station", tray_station, m_st);
    end
    for (int i = 0; i < 4; i++) begin
      send(53 * 16, 2);
      check("hyst53_station", tray_station, m_st);
    end
    check("hyst_final", tray_station, 52);
    check("hyst_pulses", pulse_cnt, m_pulses);

    // Randomized samples near the station with random gaps, back-to-back included.
    for (int i = 0; i < 40; i++) begin
      cm  = int'($urandom_range(45, 65));
      gap = int'($urandom_range(0, 3));
      send(32'(cm * 16) + $urandom_range(0, 15), gap);
      if (gap >= 1) check("rand_station", tray_station, m_st);
    end
    tick(2);
    check("rand_pulses", pulse_cnt, m_pulses);
    check("rand_valid", station_valid, m_valid);

    // Timeout into fault, then recovery on the next sample.
    tick(TO - 10);
    check("to_not_yet", sensor_fault, 0);
    tick(15);
    check("to_fault", sensor_fault, 1);
    check("to_valid", station_valid, 0);
    check("to_station_held", tray_station, m_st);
    m_state = 2;
    m_valid = 0;
    m_drops = 0;
    send(32'h1_0000, 0);
    check("recover_fault", sensor_fault, 0);
    check("recover_valid", station_valid, 0);
    for (int i = 0; i < 3; i++) send(32'h1_0000, 0);
    tick(2);
    check("sat_station", tray_station, 255);
    check("sat_valid", station_valid, 1);
    for (int i = 0; i < 4; i++) begin
      send(32'hFFFF_FFFF, 1);
      check("sat_max_station", tray_station, m_st);
    end
    for (int i = 0; i < 6; i++) begin
      send(10 * 16, 2);
      check("drop_station", tray_station, m_st);
    end
`ifndef TRAY_GLITCH_REJECT_EN
    check("drop_final", tray_station, 10);
`endif
    check("drop_pulses", pulse_cnt, m_pulses);

    // Asynchronous reset mid-cycle while tracking.
    #3 rst_n = 1'b0;
    #1;
    check("arst_station", tray_station, 0);
    check("arst_valid", station_valid, 0);
    check("arst_changed", station_changed, 0);
    check("arst_fault", sensor_fault, 0);
    model_reset();
    tick(1);
    rst_n = 1'b1;
    tick(1);
    for (int i = 0; i < 4; i++) send(30 * 16, 0);
    tick(1);
    check("refill_station", tray_station, 30);
    check("refill_valid", station_valid, 1);
    tick(1);
    check("refill_pulses", pulse_cnt, m_pulses);

`ifdef TRAY_GLITCH_REJECT_EN
    send(90 * 16, 2);
    check("spike_station", tray_station, 30);
    check("spike_pulses", pulse_cnt, m_pulses);
    send(30 * 16, 2);
    for (int i = 0; i < 3; i++) send(90 * 16, 2);
    check("spike3_valid", station_valid, 0);
    for (int i = 0; i < 3; i++) send(90 * 16, 2);
    check("spike_refill_valid", station_valid, 1);
    check("spike_refill_station", tray_station, m_st);
    check("spike_refill_pulses", pulse_cnt, m_pulses);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
